sa_result_drain: RTL and testbench
==================================

SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension (rows = lanes = N).
REQ-002 SHALL have parameter DW, default 32: accumulator width per lane at input.
REQ-003 SHALL have parameter OW, default 16: result width per lane at output.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  global advance gate; low freezes all state.
REQ-007 SHALL have port start  input  1  single-cycle request to drain one N x N result matrix.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port in_valid  input  1  skewed wavefront beat present on in_data.
REQ-010 SHALL have port in_ready  output  1  block accepts wavefront beat.
REQ-011 SHALL have port in_data  input  N*DW  lane j at bits [j*DW +: DW], signed.
REQ-012 SHALL have port out_valid  output  1  deskewed row available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts row.
REQ-014 SHALL have port out_row  output  clog2(N)  row index of out_data.
REQ-015 SHALL have port out_data  output  N*OW  deskewed row, lane j at [j*OW +: OW], signed.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last row handed off.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH, DONE; nothing advances while enable=0.
REQ-018 IDLE->RUN on start=1 with enable=1; start ignored outside IDLE.
REQ-019 in_ready SHALL be 1 only in RUN; a beat transfers when in_valid&in_ready&enable.
REQ-020 Each matrix SHALL comprise exactly 2N-1 beats t=0..2N-2; lane j carries row t-j when j<=t<=j+N-1, else don't-care.
REQ-021 Lane j SHALL be delayed by N-1-j transferred beats (beat-gated shift registers, not cycle-gated), so row r is aligned at beat t=r+N-1.
REQ-022 Aligned row SHALL be written into an N-entry row FIFO in the cycle after beat r+N-1; latency start-of-row-complete to out_valid = 1 cycle.
REQ-023 RUN->FLUSH after beat 2N-2 transfers; FLUSH->DONE when FIFO empty and row N-1 popped.
REQ-024 out_valid/out_data/out_row SHALL hold stable while out_valid=1 and out_ready=0; pop on out_valid&out_ready&enable.
REQ-025 Rows SHALL exit in order 0..N-1; simultaneous push and pop on same cycle SHALL both succeed.
REQ-026 FIFO depth N SHALL never overflow; push while full is impossible by construction.
REQ-027 DONE SHALL assert done for exactly one cycle then return to IDLE; busy=0 in IDLE.
REQ-028 Beats with in_valid=0 SHALL not advance beat counter or deskew registers.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, clear FIFO pointers, counters and deskew registers; busy, in_ready, out_valid, done=0; out_row=0, out_data=0.
REQ-030 rst mid-matrix SHALL discard all partial rows; no done pulse follows.

Configuration
REQ-031 Macro SA_DRAIN_SAT_EN defined: each lane SHALL saturate DW->OW signed (clamp to 2^(OW-1)-1 / -2^(OW-1)).
REQ-032 Macro SA_DRAIN_SAT_EN undefined: each lane SHALL truncate to low OW bits.

Verification
REQ-033 N=4: start, 7 back-to-back beats, lane j row r value = 10r+j, out_ready=1 -> rows 0..3 out in order, row 2 = {23,22,21,20}, done pulse one cycle after row 3 pop.
REQ-034 in_valid toggling 1/0 every cycle -> identical row contents as REQ-033; beat count still 7.
REQ-035 out_ready=0 until all 7 beats accepted -> out_valid held with row 0 stable; then 4 consecutive pops, done follows.
REQ-036 Lane value 40000 with SA_DRAIN_SAT_EN -> 32767; value -40000 -> -32768; without macro -> 40000 mod 2^16 = -25536.
REQ-037 rst asserted after beat 3 -> outputs zero same cycle, no done; fresh start then completes normally.
REQ-038 enable=0 for 5 cycles mid-RUN -> state, counters, outputs frozen; resumes without data loss.

Source files
------------

// File: rtl/sa_result_drain.sv
// Systolic-array result drain: deskews a skewed wavefront into whole rows and queues them.
// Define SA_DRAIN_SAT_EN to saturate each lane to OW bits instead of truncating.
module sa_result_drain #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int OW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_row,
  output logic [N*OW-1:0]        out_data,
  output logic                   done
);

  localparam int RW = $clog2(N);
  localparam int BW = $clog2(2 * N - 1);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q;
  logic [RW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [N*OW-1:0]   mem_q [N];
  logic [N*DW-1:0]   aligned;
  logic [N*OW-1:0]   row_conv;
  logic              xfer, push, pop;

`ifdef SA_DRAIN_SAT_EN
  localparam logic signed [DW-1:0] SatMax = {{(DW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [DW-1:0] SatMin = {{(DW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic [OW-1:0] conv(input logic [DW-1:0] v);
    if ($signed(v) > SatMax)      return SatMax[OW-1:0];
    else if ($signed(v) < SatMin) return SatMin[OW-1:0];
    else                          return v[OW-1:0];
  endfunction
`else
  function automatic logic [OW-1:0] conv(input logic [DW-1:0] v);
    return v[OW-1:0];
  endfunction
`endif

  assign in_ready  = (state_q == StRun);
  assign xfer      = in_valid & in_ready & enable;
  // Row r completes on beat r+N-1, so the first N-1 beats only prime the deskew lines.
  assign push      = xfer & (beat_q >= BW'(N - 1));
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready & enable;
  assign busy      = (state_q == StRun) || (state_q == StFlush);
  assign done      = (state_q == StDone);
  assign out_row   = rd_ptr_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Lane j is delayed by N-1-j transferred beats; the last lane passes straight through.
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned[j*DW +: DW] = in_data[j*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] sr_q [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) sr_q[k] <= '0;
        end else if (xfer) begin
          sr_q[0] <= in_data[j*DW +: DW];
          for (int k = 1; k < D; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign aligned[j*DW +: DW] = sr_q[D-1];
    end
    assign row_conv[j*OW +: OW] = conv(aligned[j*DW +: DW]);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= row_conv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start && enable) beat_q <= '0;
      else if (xfer)                            beat_q <= beat_q + 1'b1;
      if (push) wr_ptr_q <= (wr_ptr_q == RW'(N - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == RW'(N - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && enable) state_d = StRun;
      StRun:   if (xfer && beat_q == BW'(2 * N - 2)) state_d = StFlush;
      StFlush: if (pop && rd_ptr_q == RW'(N - 1) && cnt_q == CW'(1)) state_d = StDone;
      StDone:  if (enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Randomized scoreboard bench for sa_result_drain; row expectations come from the matrix itself.
module tb_sa_result_drain;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 16;

  logic                  clk = 0;
  logic                  rst, enable, start, busy, in_valid, in_ready, out_valid, out_ready, done;
  logic [N*DW-1:0]       in_data;
  logic [$clog2(N)-1:0]  out_row;
  logic [N*OW-1:0]       out_data;

  sa_result_drain #(.N(N), .DW(DW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int row; logic [N*OW-1:0] data;} exp_t;
  exp_t exp_q[$];

  int nchk = 0, nerr = 0;
  int cyc = 0;
  int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
  int done_cnt = 0, done_exp = 0, last_pop_cyc = -10;
  int mat [N][N];
  logic done_prev = 0;
  logic hold_pend = 0;
  logic [N*OW-1:0] hold_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] model_conv(input longint v);
`ifdef SA_DRAIN_SAT_EN
    longint hi, lo;
    hi = (64'sd1 <<< (OW - 1)) - 1;
    lo = -(64'sd1 <<< (OW - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
`endif
    return v[OW-1:0];  // two's-complement low bits = value mod 2^OW
  endfunction

  function automatic int rand_val();
    if ($urandom_range(0, 1) == 1) return int'($urandom);
    return int'($urandom_range(0, 100000)) - 50000;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int r = 0; r < N; r++) begin
      e.row = r;
      for (int j = 0; j < N; j++) e.data[j*OW +: OW] = model_conv(longint'(mat[r][j]));
      exp_q.push_back(e);
    end
  endtask

  // Monitor: owns out_ready, pops the scoreboard on every handshake.
  initial begin
    exp_t e;
    out_ready = 0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 1) == 1);
        1:       out_ready = 1;
        default: out_ready = 0;
      endcase
      #1;
      if (hold_pend && !rst) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(hold_data));
      end
      hold_pend = out_valid && !(out_ready && enable) && !rst;
      hold_data = out_data;
      if (out_valid && out_ready && enable && !rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 64'(out_row), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("row_index", 64'(out_row), 64'(e.row));
          chk("row_data", 64'(out_data), 64'(e.data));
          if (e.row == N - 1) last_pop_cyc = cyc;
        end
      end
      if (done && !done_prev) begin
        done_cnt++;
        chk("done_after_last_pop", 64'(cyc), 64'(last_pop_cyc + 1));
      end
      done_prev = done;
    end
  end

  task automatic do_start();
    @(negedge clk);
    enable = 1;
    start  = 1;
    @(negedge clk);
    start = 0;
    #1 chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic freeze();
    logic sv, sb, sr;
    logic [N*OW-1:0] sd;
    logic [$clog2(N)-1:0] so;
    @(negedge clk);
    enable   = 0;
    in_valid = ($urandom_range(0, 1) == 1);
    #1;
    sv = out_valid; sb = busy; sr = in_ready; sd = out_data; so = out_row;
    repeat (4) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("frz_valid", 64'(out_valid), 64'(sv));
      chk("frz_busy", 64'(busy), 64'(sb));
      chk("frz_ready", 64'(in_ready), 64'(sr));
      chk("frz_data", 64'(out_data), 64'(sd));
      chk("frz_row", 64'(out_row), 64'(so));
    end
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random gaps (with a stray start mid-run).
  task automatic send_matrix(input int vmode, input int freeze_at, input int abort_at);
    logic tog;
    logic sent;
    int guard, d0;
    tog = 1;
    push_expected();
    do_start();
    for (int t = 0; t < 2 * N - 1; t++) begin
      if (t == freeze_at) freeze();
      sent = 0;
      guard = 0;
      while (!sent) begin
        @(negedge clk);
        enable = 1;
        start  = (vmode == 2 && t == 2);
        case (vmode)
          0:       in_valid = 1;
          1:       begin in_valid = tog; tog = !tog; end
          default: in_valid = ($urandom_range(0, 3) != 0);
        endcase
        for (int j = 0; j < N; j++)
          in_data[j*DW +: DW] = (in_valid && t >= j && t <= j + N - 1) ? mat[t-j][j] : $urandom;
        #1;
        if (in_valid && in_ready) sent = 1;
        else if (++guard > 50) begin
          chk("beat_accept_timeout", 64'(in_ready), 64'd1);
          return;
        end
      end
      if (t == abort_at) begin
        @(negedge clk);
        in_valid = 0;
        start    = 0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        exp_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);
        #2 chk("no_done_after_rst", 64'(done_cnt), 64'(d0));
        return;
      end
    end
    @(negedge clk);
    in_valid = 0;
    start    = 0;
  endtask

  task automatic wait_done();
    int guard;
    done_exp++;
    guard = 0;
    while (done_cnt < done_exp && guard < 300) begin
      @(negedge clk);
      #2;
      guard++;
    end
    chk("done_seen", 64'(done_cnt), 64'(done_exp));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    #2;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic fill_fixed();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) mat[r][j] = 10 * r + j;
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) mat[r][j] = rand_val();
  endtask

  initial begin
    rst = 1; enable = 0; start = 0; in_valid = 0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 0;

    // Fixed 10r+j matrix, back-to-back beats then toggling valid.
    rdy_mode = 1;
    fill_fixed();
    send_matrix(0, -1, -1);
    wait_done();
    send_matrix(1, -1, -1);
    wait_done();

    // Consumer stalls until every beat is in; all rows wait in the queue.
    rdy_mode = 2;
    send_matrix(0, -1, -1);
    @(negedge clk);
    #1;
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_row", 64'(out_row), 64'd0);
    rdy_mode = 1;
    wait_done();

    // Out-of-range lanes around the OW boundary.
    fill_random();
    for (int r = 0; r < N; r++) begin
      mat[r][r]         = 40000;
      mat[r][N - 1 - r] = -40000;
    end
    mat[0][1] = 32767;
    mat[1][0] = -32768;
    send_matrix(0, -1, -1);
    wait_done();

    // Enable dropped mid-run with random back-pressure.
    rdy_mode = 0;
    fill_random();
    send_matrix(2, 3, -1);
    wait_done();

    // Reset after beat 3, then a clean matrix.
    rdy_mode = 2;
    fill_random();
    send_matrix(0, -1, 3);
    rdy_mode = 1;
    fill_fixed();
    send_matrix(0, -1, -1);
    wait_done();

    rdy_mode = 0;
    for (int m = 0; m < 8; m++) begin
      fill_random();
      send_matrix(int'($urandom_range(0, 2)), (m % 3 == 0) ? 5 : -1, -1);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
